// File: rtl/icache_assoc.sv
// Set-associative instruction cache with word-serial line refill from MemCtrl,
// per-set round-robin victim selection and rollback-safe refill abort.
module icache_assoc #(
    parameter int unsigned INDEX_W    = 6,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        full,
    input  logic [31:0] MC_val,
    input  logic        MC_val_sgn,
    output logic [31:0] Mc_addr,
    output logic        Mc_addr_sgn,
    input  logic [31:0] IF_addr,
    input  logic        IF_addr_sgn,
    output logic [31:0] IF_val,
    output logic        IF_val_sgn
);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned WORD_W = (OFF_W == 0) ? 1 : OFF_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_W  = 32 - 2 - OFF_W - INDEX_W;
    localparam int unsigned SETS   = 1 << INDEX_W;
    localparam int unsigned LINE_B = LINE_WORDS * 4;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    // Cache arrays and per-set victim pointers
    logic               valid_q  [WAYS][SETS];
    logic [TAG_W-1:0]   tag_q    [WAYS][SETS];
    logic [31:0]        data_q   [WAYS][SETS][LINE_WORDS];
    logic [WAY_W-1:0]   victim_q [SETS];
    logic [31:0]        buf_q    [LINE_WORDS];

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0]  off_q, off_d;
    logic [31:0]        base_q, base_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [TAG_W-1:0]   tag_lat_q, tag_lat_d;
    logic               abort_q, abort_d;
    logic [31:0]        mc_addr_d, if_val_d;
    logic               mc_sgn_d, if_sgn_d;
    logic               install, buf_we;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [WORD_W-1:0]  req_word;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [31:0]        hit_word;
    logic [WAY_W-1:0]   victim_way, next_victim;

    assign req_index = INDEX_W'(IF_addr >> (2 + OFF_W));
    assign req_tag   = TAG_W'(IF_addr >> (2 + OFF_W + INDEX_W));
    assign req_word  = WORD_W'((IF_addr >> 2) & 32'(LINE_WORDS - 1));

    // Tag lookup; descending scan so the lowest-numbered matching way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[w][req_index] && tag_q[w][req_index] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_word    = data_q[hit_way][req_index][req_word];
    assign victim_way  = victim_q[idx_q];
    assign next_victim = (victim_way == LAST_WAY) ? '0 : victim_way + WAY_W'(1);

    // Next-state and output logic; rdy low leaves everything at its held value
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        base_d    = base_q;
        idx_d     = idx_q;
        tag_lat_d = tag_lat_q;
        abort_d   = abort_q;
        mc_addr_d = Mc_addr;
        mc_sgn_d  = Mc_addr_sgn;
        if_val_d  = IF_val;
        if_sgn_d  = 1'b0;
        install   = 1'b0;
        buf_we    = 1'b0;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (!rollback && IF_addr_sgn && !full) begin
                        if (hit) begin
                            if_val_d = hit_word;
                            if_sgn_d = 1'b1;
                        end else begin
                            base_d    = IF_addr & ~32'(LINE_B - 1);
                            idx_d     = req_index;
                            tag_lat_d = req_tag;
                            off_d     = req_word;
                            cnt_d     = '0;
                            state_d   = REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (Mc_addr_sgn) begin
                        if (MC_val_sgn) begin
                            mc_sgn_d = 1'b0;
                            if (abort_q || rollback) begin
                                abort_d = 1'b0;
                                state_d = IDLE;
                            end else begin
                                buf_we = 1'b1;
                                if (cnt_q == off_q) if_val_d = MC_val;
                                if (cnt_q == LAST_WORD) begin
                                    install = 1'b1;
                                    state_d = RESP;
                                end else begin
                                    cnt_d = cnt_q + WORD_W'(1);
                                end
                            end
                        end else if (rollback) begin
                            abort_d = 1'b1;
                        end
                    end else if (rollback) begin
                        state_d = IDLE;
                    end else begin
                        mc_sgn_d  = 1'b1;
                        mc_addr_d = base_q | 32'({cnt_q, 2'b00});
                    end
                end
                RESP: begin
                    if (rollback) begin
                        state_d = IDLE;
                    end else if (!full) begin
                        if_sgn_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            tag_lat_q   <= '0;
            abort_q     <= 1'b0;
            Mc_addr     <= '0;
            Mc_addr_sgn <= 1'b0;
            IF_val      <= '0;
            IF_val_sgn  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            tag_lat_q   <= tag_lat_d;
            abort_q     <= abort_d;
            Mc_addr     <= mc_addr_d;
            Mc_addr_sgn <= mc_sgn_d;
            IF_val      <= if_val_d;
            IF_val_sgn  <= if_sgn_d;
        end
    end

    // Valid bits and victim pointers are the only array state that needs reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                for (int s = 0; s < int'(SETS); s++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
            for (int s = 0; s < int'(SETS); s++) begin
                victim_q[s] <= '0;
            end
        end else if (install) begin
            valid_q[victim_way][idx_q] <= 1'b1;
            victim_q[idx_q]            <= next_victim;
        end
    end

    // Refill buffer and line install; the final word is taken straight from MemCtrl
    always_ff @(posedge clk) begin
        if (!rst && buf_we) begin
            buf_q[cnt_q] <= MC_val;
        end
        if (!rst && install) begin
            tag_q[victim_way][idx_q] <= tag_lat_q;
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
                data_q[victim_way][idx_q][i] <= (WORD_W'(i) == cnt_q) ? MC_val : buf_q[i];
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (INDEX_W=4, WAYS=2, LINE_WORDS=4) with a
// MemCtrl model of return latency 3; table-driven fetches plus corner sequences.
module tb_icache_assoc;
    localparam int unsigned MISS_LAT = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        full = 1'b0;
    logic [31:0] MC_val;
    logic        MC_val_sgn;
    logic [31:0] Mc_addr;
    logic        Mc_addr_sgn;
    logic [31:0] IF_addr = '0;
    logic        IF_addr_sgn = 1'b0;
    logic [31:0] IF_val;
    logic        IF_val_sgn;

    logic        model_sgn = 1'b0;
    logic        spur = 1'b0;
    int          model_cnt = 0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulse_cnt = 0;
    logic        prev_req = 1'b0;
    logic [31:0] reqs[$];
    int          lat;
    int          p0;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        bit          miss;
    } vec_t;
    vec_t tbl [18];

    icache_assoc #(.INDEX_W(4), .WAYS(2), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .full(full),
        .MC_val(MC_val), .MC_val_sgn(MC_val_sgn),
        .Mc_addr(Mc_addr), .Mc_addr_sgn(Mc_addr_sgn),
        .IF_addr(IF_addr), .IF_addr_sgn(IF_addr_sgn),
        .IF_val(IF_val), .IF_val_sgn(IF_val_sgn)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // MemCtrl: answers after the request has been high for 3 cycles, stalls on rdy
    assign MC_val_sgn = model_sgn | spur;
    always @(posedge clk) begin
        if (rst) begin
            model_sgn <= 1'b0;
            model_cnt <= 0;
            MC_val    <= '0;
        end else if (rdy) begin
            if (model_sgn) begin
                model_sgn <= 1'b0;
            end else if (Mc_addr_sgn) begin
                if (model_cnt == 1) begin
                    model_sgn <= 1'b1;
                    MC_val    <= mem_word(Mc_addr);
                    model_cnt <= 0;
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (Mc_addr_sgn && !prev_req) reqs.push_back(Mc_addr);
        prev_req = Mc_addr_sgn;
        if (IF_val_sgn) pulse_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " IF_val"}, IF_val, 32'h0);
        check({name, " IF_val_sgn"}, 32'(IF_val_sgn), 32'h0);
        check({name, " Mc_addr_sgn"}, 32'(Mc_addr_sgn), 32'h0);
        check({name, " Mc_addr"}, Mc_addr, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; full = 1'b0; spur = 1'b0;
        IF_addr_sgn = 1'b0; IF_addr = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
    endtask

    task automatic run_fetch(input string name, input logic [31:0] a, input int exp_lat, input bit miss);
        int l;
        logic [31:0] base;
        @(negedge clk);
        check({name, " pulse width"}, 32'(IF_val_sgn), 32'h0);
        reqs.delete();
        IF_addr = a; IF_addr_sgn = 1'b1; l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!IF_val_sgn && l < 60);
        IF_addr_sgn = 1'b0;
        check({name, " latency"}, 32'(l), 32'(exp_lat));
        check({name, " word"}, IF_val, mem_word(a));
        base = a & ~32'hF;
        if (miss) begin
            check({name, " req count"}, 32'(reqs.size()), 32'd4);
            for (int k = 0; k < reqs.size(); k++)
                check($sformatf("%s req%0d", name, k), reqs[k], base + 32'(4 * k));
        end else begin
            check({name, " no req"}, 32'(reqs.size()), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // set 0 holds 0x100/0x500/0x900/0x200 lines; pointer order tracked by hand
        tbl[0]  = '{32'h100, MISS_LAT, 1'b1};
        tbl[1]  = '{32'h104, 1, 1'b0};
        tbl[2]  = '{32'h108, 1, 1'b0};
        tbl[3]  = '{32'h10C, 1, 1'b0};
        tbl[4]  = '{32'h500, MISS_LAT, 1'b1};
        tbl[5]  = '{32'h504, 1, 1'b0};
        tbl[6]  = '{32'h900, MISS_LAT, 1'b1};
        tbl[7]  = '{32'h500, 1, 1'b0};
        tbl[8]  = '{32'h100, MISS_LAT, 1'b1};
        tbl[9]  = '{32'h908, 1, 1'b0};
        tbl[10] = '{32'h500, MISS_LAT, 1'b1};
        tbl[11] = '{32'h208, MISS_LAT, 1'b1};
        tbl[12] = '{32'h200, 1, 1'b0};
        tbl[13] = '{32'h504, 1, 1'b0};
        tbl[14] = '{32'h104, MISS_LAT, 1'b1};
        tbl[15] = '{32'h20C, 1, 1'b0};
        tbl[16] = '{32'h110, MISS_LAT, 1'b1};
        tbl[17] = '{32'h11C, 1, 1'b0};

        do_reset();
        for (int i = 0; i < 18; i++)
            run_fetch($sformatf("vec%0d", i), tbl[i].addr, tbl[i].lat, tbl[i].miss);

        // Rollback while the 0x104 request is outstanding
        do_reset();
        @(negedge clk);
        reqs.delete(); p0 = pulse_cnt;
        IF_addr = 32'h100; IF_addr_sgn = 1'b1; lat = 0;
        while (!(Mc_addr_sgn && Mc_addr == 32'h104) && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("rb reach 104", 32'(lat), 32'd6);
        rollback = 1'b1; IF_addr_sgn = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        check("rb no pulse", 32'(IF_val_sgn), 32'h0);
        check("rb held req", 32'(Mc_addr_sgn), 32'h1);
        @(negedge clk);
        check("rb mc return", 32'(MC_val_sgn), 32'h1);
        check("rb req until return", 32'(Mc_addr_sgn), 32'h1);
        @(negedge clk);
        check("rb req dropped", 32'(Mc_addr_sgn), 32'h0);
        repeat (8) @(negedge clk);
        check("rb no new req", 32'(reqs.size()), 32'd2);
        check("rb pulses", 32'(pulse_cnt), 32'(p0));
        run_fetch("rb refetch", 32'h100, MISS_LAT, 1'b1);

        // full holds back a hit; spurious MC_val_sgn is ignored in IDLE
        @(negedge clk);
        full = 1'b1; IF_addr = 32'h104; IF_addr_sgn = 1'b1; p0 = pulse_cnt;
        repeat (4) @(negedge clk);
        check("full hit held", 32'(pulse_cnt), 32'(p0));
        full = 1'b0;
        @(negedge clk);
        IF_addr_sgn = 1'b0;
        check("full hit pulse", 32'(IF_val_sgn), 32'h1);
        check("full hit word", IF_val, mem_word(32'h104));
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur no req", 32'(Mc_addr_sgn), 32'h0);
        run_fetch("spur hit", 32'h108, 1, 1'b0);

        // full raised during refill: line installs, response waits in RESP
        do_reset();
        @(negedge clk);
        reqs.delete(); p0 = pulse_cnt;
        IF_addr = 32'h300; IF_addr_sgn = 1'b1;
        @(negedge clk);
        full = 1'b1;
        repeat (25) @(negedge clk);
        check("resp held", 32'(pulse_cnt), 32'(p0));
        check("resp reqs", 32'(reqs.size()), 32'd4);
        full = 1'b0;
        @(negedge clk);
        IF_addr_sgn = 1'b0;
        check("resp pulse", 32'(IF_val_sgn), 32'h1);
        check("resp word", IF_val, mem_word(32'h300));
        run_fetch("resp installed", 32'h30C, 1, 1'b0);

        // rdy low for 5 cycles mid-refill shifts the response by 5
        do_reset();
        @(negedge clk);
        reqs.delete();
        IF_addr = 32'h700; IF_addr_sgn = 1'b1; lat = 0;
        while (lat < 80) begin
            @(negedge clk);
            lat++;
            if (lat == 6) begin
                check("stall start addr", Mc_addr, 32'h704);
                check("stall start sgn", 32'(Mc_addr_sgn), 32'h1);
                rdy = 1'b0;
            end
            if (lat == 11) begin
                check("stall held addr", Mc_addr, 32'h704);
                check("stall held sgn", 32'(Mc_addr_sgn), 32'h1);
                rdy = 1'b1;
            end
            if (IF_val_sgn) break;
        end
        IF_addr_sgn = 1'b0;
        check("stall latency", 32'(lat), 32'(MISS_LAT + 5));
        check("stall word", IF_val, mem_word(32'h700));
        check("stall reqs", 32'(reqs.size()), 32'd4);

        // Reset during a refill drops everything cached
        do_reset();
        run_fetch("pre rst a", 32'h100, MISS_LAT, 1'b1);
        run_fetch("pre rst b", 32'h500, MISS_LAT, 1'b1);
        @(negedge clk);
        IF_addr = 32'h900; IF_addr_sgn = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; IF_addr_sgn = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid rst");
        rst = 1'b0;
        run_fetch("post rst a", 32'h100, MISS_LAT, 1'b1);
        run_fetch("post rst b", 32'h500, MISS_LAT, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache between the instruction fetch unit and the memory controller. Multi-word lines are refilled one word at a time from MemCtrl through a small refill state machine. A per-set round-robin pointer selects the victim way. Hits respond one cycle after request; misses stall fetch until the whole line is installed. Rollback cleanly abandons a refill.

## Interface
- `INDEX_W`, default 6: set index bits; sets = 2^INDEX_W.
- `WAYS`, default 2: associativity, power of two, 1..8.
- `LINE_WORDS`, default 4: 32-bit words per line, power of two, 1..16.
- `OFF_W`, derived: log2(LINE_WORDS); address split is tag = [31:2+OFF_W+INDEX_W], index = [2+OFF_W+INDEX_W-1:2+OFF_W], word = [2+OFF_W-1:2]; bits [1:0] are ignored.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global ready; low freezes the block.
- `rollback`  in  1  pipeline flush.
- `full`  in  1  downstream fetch queue full; suppresses new responses and new refills.
- `MC_val`  in  32  word returned by MemCtrl.
- `MC_val_sgn`  in  1  one-cycle pulse, `MC_val` valid.
- `Mc_addr`  out  32  word address requested from MemCtrl.
- `Mc_addr_sgn`  out  1  registered request level, held until the matching `MC_val_sgn`.
- `IF_addr`  in  32  fetch PC; held stable by IF while `IF_addr_sgn` is high and no response has been given.
- `IF_addr_sgn`  in  1  fetch request level.
- `IF_val`  out  32  instruction.
- `IF_val_sgn`  out  1  one-cycle response pulse.

## Operation
- Storage per way per set: valid bit, tag, and LINE_WORDS data words. Each set also holds a victim pointer of log2(WAYS) bits.
- **FSM states:** IDLE, REFILL, RESP.
- **IDLE**
  - `IF_addr_sgn` and `!full`, hit in any way: `IF_val` = hit word, `IF_val_sgn` = 1 next cycle; stay IDLE.
  - `IF_addr_sgn` and `!full`, miss: latch the line base (`IF_addr` with word and byte bits cleared), index, tag and word offset. Clear the word counter and go to REFILL.
  - `full` high: no response, no refill start.
- **REFILL**
  - Requests words base+0, +4, … , +4·(LINE_WORDS−1) in order, one outstanding at a time.
  - `Mc_addr_sgn` rises the cycle after entry, or the cycle after the previous `MC_val_sgn`. It falls on the edge that samples `MC_val_sgn`.
  - Each returned word goes into the refill buffer at the counter position. The requested word is also captured into `IF_val`.
  - After the last word: install tag, data and valid=1 into the way named by the set's victim pointer. The pointer increments mod WAYS. Go to RESP.
  - `full` has no effect on an in-progress refill.
- **RESP:** while `!full`, `IF_val_sgn` = 1 for one cycle, then go to IDLE. While `full`, hold in RESP.
- **Rollback**
  - `IF_val_sgn` is 0 on the next cycle.
  - In IDLE or RESP: go to IDLE with no pulse.
  - In REFILL with no request outstanding: go to IDLE.
  - In REFILL with a request outstanding: set `abort`, keep `Mc_addr_sgn` high until `MC_val_sgn`, discard that word, then go to IDLE.
  - An aborted line is never installed and the victim pointer is unchanged.
- **rdy low:** no state, array or pointer change; `IF_val_sgn` forced 0; `Mc_addr_sgn` and `Mc_addr` hold their values. MemCtrl also stalls on `rdy`.
- **Hit-way priority:** at most one way can hit. If several ever do, the lowest-numbered way wins.

## Timing
- **Reset** (`rst` wins over `rollback` and `rdy`):
  - every valid bit is 0 and every victim pointer is 0;
  - state is IDLE and `abort` is 0;
  - `IF_val` = 0, `IF_val_sgn` = 0, `Mc_addr_sgn` = 0, `Mc_addr` = 0.
- Reset mid-refill drops the refill. MemCtrl is reset by the same `rst`.
- **Hit latency:** request sampled at edge t, `IF_val_sgn` high in cycle t+1.
- **Miss latency:** with a MemCtrl return latency of L cycles per word, `IF_val_sgn` arrives LINE_WORDS·(L+1)+2 cycles after the request.
- **Array update:** takes effect on the edge that samples the last `MC_val_sgn`. A request in the following IDLE cycle hits the new line.
- `MC_val_sgn` with no outstanding request is ignored.

## Test plan
Configuration for all scenarios: INDEX_W=4, WAYS=2, LINE_WORDS=4, MemCtrl model with L=3.

- **Cold miss then hits:** after reset, fetch 0x100.
  - `Mc_addr` steps 0x100, 0x104, 0x108, 0x10C.
  - `IF_val_sgn` comes 18 cycles after the request, with the 0x100 word.
  - Fetches of 0x104..0x10C each hit with 1-cycle latency.
- **Associativity and replacement:** fill 0x100 and 0x500 (same set), then fetch 0x900.
  - 0x900 evicts the 0x100 line (pointer 0); 0x500 still hits; 0x100 misses.
  - Its refill then evicts 0x500.
- **Critical word:** cold fetch 0x208 → `IF_val` equals the memory word at 0x208, refill order still starts at 0x200.
- **Rollback mid-refill:** assert `rollback` while the request for 0x104 is outstanding.
  - `Mc_addr_sgn` stays high until its `MC_val_sgn`, then drops.
  - No `IF_val_sgn`; a later fetch of 0x100 misses again.
- **full and rdy:**
  - A hit presented with `full`=1 gives no pulse until `full`=0.
  - During a refill with `full`=1 the line still installs and the FSM waits in RESP.
  - `rdy`=0 for 5 cycles mid-refill shifts every event by exactly 5 cycles.
- **Reset mid-operation:** `rst` during REFILL gives all outputs 0 next cycle, and every prior line misses afterwards.
